// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-lite master: turns one command into one AXI-lite read or
// write and returns a single response. All AXI and response outputs are registered.
module axil_cmd_master #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,

    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,

    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,

    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,

    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    bready_q, bready_d;
    logic                    rready_q, rready_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_we) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                // AW and W retire independently; leave once neither is pending
                if (m_axil_awready) awvalid_d = 1'b0;
                if (m_axil_wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (m_axil_bvalid) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (m_axil_bresp != 2'b00);
                    rsp_rdata_d = '0;
                end
            end
            RD_REQ: begin
                if (m_axil_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axil_rvalid) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (m_axil_rresp != 2'b00);
                    rsp_rdata_d = m_axil_rdata;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Ready strobes are registered copies of the state they belong to
        cmd_ready_d = (state_d == IDLE);
        bready_d    = (state_d == WR_RESP);
        rready_d    = (state_d == RD_DATA);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_rdata      = rsp_rdata_q;

    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: a table of commands run against a small
// AXI-lite RAM responder with per-vector stall settings, plus reset sequences.
module tb_axil_cmd_master;

    localparam int DW = 128;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic          clk;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
    logic [2:0]    m_axil_awprot, m_axil_arprot;
    logic          m_axil_awvalid, m_axil_awready;
    logic [DW-1:0] m_axil_wdata, m_axil_rdata;
    logic [SW-1:0] m_axil_wstrb;
    logic          m_axil_wvalid, m_axil_wready;
    logic [1:0]    m_axil_bresp, m_axil_rresp;
    logic          m_axil_bvalid, m_axil_bready;
    logic          m_axil_arvalid, m_axil_arready;
    logic          m_axil_rvalid, m_axil_rready;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem [0:63];

    axil_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // a_dly: AW (write) or AR (read) stall cycles; d_dly: B/R delay after the request
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        int            a_dly;
        int            w_dly;
        int            d_dly;
        logic [1:0]    bresp;
        logic [1:0]    rresp;
        int            rsp_dly;
        logic          early;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [0:10];

    function automatic vec_t mkv(input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb,
                                 input int a_dly, input int w_dly, input int d_dly,
                                 input logic [1:0] bresp, input logic [1:0] rresp,
                                 input int rsp_dly, input logic early,
                                 input logic exp_err, input logic [DW-1:0] exp_rdata);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.a_dly = a_dly; v.w_dly = w_dly; v.d_dly = d_dly;
        v.bresp = bresp; v.rresp = rresp; v.rsp_dly = rsp_dly; v.early = early;
        v.exp_err = exp_err; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic slave_idle();
        m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_arready = 1'b0;
        m_axil_bvalid  = 1'b0; m_axil_rvalid = 1'b0; rsp_ready = 1'b0;
        m_axil_bresp   = 2'b00; m_axil_rresp = 2'b00; m_axil_rdata = '0;
    endtask

    // Entered and left on a falling edge: outputs are sampled and inputs driven there.
    task automatic run_vec(input int idx, input vec_t v);
        int aw_wait, w_wait, rsp_wait, viol, aw_cyc, w_cyc, br_win, rsp_cyc, acc_cyc, wr_cyc, rd_cyc;
        bit accepted, aw_done, w_done, ar_done, b_done, r_done, rsp_done, mem_done;
        logic [AW-1:0] cap_addr, prev_awaddr, prev_araddr;
        logic [DW-1:0] cap_wdata, prev_wdata, got_rdata, prev_rsp_rdata;
        logic [SW-1:0] cap_wstrb, prev_wstrb;
        logic          got_err, prev_rsp_err;
        logic          prev_awv, prev_awr, prev_wv, prev_wr, prev_arv, prev_arr, prev_br, prev_rspv;
        aw_wait = v.a_dly; w_wait = v.w_dly; rsp_wait = v.rsp_dly;
        viol = 0; aw_cyc = 0; w_cyc = 0; br_win = 0; rsp_cyc = 0;
        acc_cyc = -10; wr_cyc = 0; rd_cyc = 0;
        accepted = 0; aw_done = 0; w_done = 0; ar_done = 0; b_done = 0; r_done = 0;
        rsp_done = 0; mem_done = 0;
        cap_addr = '0; cap_wdata = '0; cap_wstrb = '0; got_rdata = '0; got_err = 1'b0;
        prev_awaddr = '0; prev_araddr = '0; prev_wdata = '0; prev_wstrb = '0;
        prev_rsp_rdata = '0; prev_rsp_err = 1'b0;
        prev_awv = 0; prev_awr = 0; prev_wv = 0; prev_wr = 0; prev_arv = 0; prev_arr = 0;
        prev_br = 0; prev_rspv = 0;

        cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;

        for (int cyc = 0; cyc < 300 && !rsp_done; cyc++) begin
            if (accepted) cmd_valid = 1'b0;
            else if (cmd_valid && cmd_ready) begin
                accepted = 1'b1;
                acc_cyc  = cyc;
            end
            if ((!accepted || cyc == acc_cyc) && (m_axil_awvalid || m_axil_wvalid || m_axil_arvalid))
                viol++;
            if (cyc == acc_cyc + 1 && (v.we ? !(m_axil_awvalid && m_axil_wvalid) : !m_axil_arvalid))
                viol++;

            // AW
            if (prev_awv && !prev_awr && (!m_axil_awvalid || m_axil_awaddr != prev_awaddr)) viol++;
            if (m_axil_awvalid && (aw_done || !v.we)) viol++;
            m_axil_awready = 1'b0;
            if (m_axil_awvalid && !aw_done && v.we) begin
                aw_cyc++;
                if (aw_wait == 0) begin
                    m_axil_awready = 1'b1; aw_done = 1'b1; cap_addr = m_axil_awaddr;
                end else aw_wait--;
            end

            // W
            if (prev_wv && !prev_wr && (!m_axil_wvalid || m_axil_wdata != prev_wdata ||
                                        m_axil_wstrb != prev_wstrb)) viol++;
            if (m_axil_wvalid && (w_done || !v.we)) viol++;
            m_axil_wready = 1'b0;
            if (m_axil_wvalid && !w_done && v.we) begin
                w_cyc++;
                if (w_wait == 0) begin
                    m_axil_wready = 1'b1; w_done = 1'b1;
                    cap_wdata = m_axil_wdata; cap_wstrb = m_axil_wstrb;
                end else w_wait--;
            end
            if (aw_done && w_done && !mem_done) begin
                mem_done = 1'b1;
                wr_cyc   = cyc;
                for (int b = 0; b < SW; b++)
                    if (cap_wstrb[b]) mem[cap_addr[9:4]][8*b +: 8] = cap_wdata[8*b +: 8];
            end

            // B
            if (m_axil_bready && !(mem_done && cyc > wr_cyc)) viol++;
            if (m_axil_bready && !prev_br) br_win++;
            m_axil_bresp  = v.bresp;
            m_axil_bvalid = v.we && !b_done &&
                            ((v.early && accepted) || (mem_done && cyc > wr_cyc + v.d_dly));
            if (m_axil_bvalid && m_axil_bready) b_done = 1'b1;

            // AR
            if (prev_arv && !prev_arr && (!m_axil_arvalid || m_axil_araddr != prev_araddr)) viol++;
            if (m_axil_arvalid && (ar_done || v.we)) viol++;
            m_axil_arready = 1'b0;
            if (m_axil_arvalid && !ar_done && !v.we) begin
                aw_cyc++;
                if (aw_wait == 0) begin
                    m_axil_arready = 1'b1; ar_done = 1'b1; cap_addr = m_axil_araddr; rd_cyc = cyc;
                end else aw_wait--;
            end

            // R
            if (m_axil_rready && !(ar_done && cyc > rd_cyc)) viol++;
            m_axil_rresp  = v.rresp;
            m_axil_rdata  = mem[v.addr[9:4]];
            m_axil_rvalid = !v.we && !r_done &&
                            ((v.early && accepted) || (ar_done && cyc > rd_cyc + v.d_dly));
            if (m_axil_rvalid && m_axil_rready) r_done = 1'b1;

            // Response
            if (prev_rspv && (!rsp_valid || rsp_rdata != prev_rsp_rdata || rsp_err != prev_rsp_err))
                viol++;
            rsp_ready = 1'b0;
            if (rsp_valid) begin
                rsp_cyc++;
                if (!(b_done || r_done)) viol++;
                if (cmd_ready || m_axil_awvalid || m_axil_wvalid || m_axil_arvalid ||
                    m_axil_bready || m_axil_rready) viol++;
                if (rsp_wait == 0) begin
                    rsp_ready = 1'b1; rsp_done = 1'b1; got_rdata = rsp_rdata; got_err = rsp_err;
                end else rsp_wait--;
            end

            prev_awv = m_axil_awvalid; prev_awr = m_axil_awready; prev_awaddr = m_axil_awaddr;
            prev_wv  = m_axil_wvalid;  prev_wr  = m_axil_wready;
            prev_wdata = m_axil_wdata; prev_wstrb = m_axil_wstrb;
            prev_arv = m_axil_arvalid; prev_arr = m_axil_arready; prev_araddr = m_axil_araddr;
            prev_br  = m_axil_bready;
            prev_rspv = rsp_valid; prev_rsp_rdata = rsp_rdata; prev_rsp_err = rsp_err;
            @(negedge clk);
        end
        slave_idle();
        cmd_valid = 1'b0;

        check($sformatf("v%0d_done", idx), DW'(rsp_done), DW'(1));
        check($sformatf("v%0d_rdata", idx), got_rdata, v.exp_rdata);
        check($sformatf("v%0d_err", idx), DW'(got_err), DW'(v.exp_err));
        check($sformatf("v%0d_addr", idx), DW'(cap_addr), DW'(v.addr));
        check($sformatf("v%0d_protocol", idx), DW'(viol), DW'(0));
        check($sformatf("v%0d_req_cycles", idx), DW'(aw_cyc), DW'(v.a_dly + 1));
        check($sformatf("v%0d_bready_windows", idx), DW'(br_win), DW'(v.we ? 1 : 0));
        check($sformatf("v%0d_rsp_cycles", idx), DW'(rsp_cyc), DW'(v.rsp_dly + 1));
        check($sformatf("v%0d_idle_after_rsp", idx), DW'({cmd_ready, rsp_valid}), DW'(2'b10));
        if (v.we) begin
            check($sformatf("v%0d_wdata", idx), cap_wdata, v.wdata);
            check($sformatf("v%0d_wstrb", idx), DW'(cap_wstrb), DW'(v.wstrb));
            check($sformatf("v%0d_w_cycles", idx), DW'(w_cyc), DW'(v.w_dly + 1));
        end
        $display("vec %0d we=%0d addr=%h err=%0d rdata=%h", idx, v.we, v.addr, got_err, got_rdata);
    endtask

    localparam logic [DW-1:0] W_A = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [DW-1:0] W_F = {DW{1'b1}};
    localparam logic [DW-1:0] W_X = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [DW-1:0] W_D = 128'hDEADBEEFCAFEF00D123456789ABCDEF0;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        //               we    addr          wdata  wstrb       a  w  d  bresp  rresp  rsp e  err  exp_rdata
        vecs[0]  = mkv(1'b1, 32'h0000_1000, W_A, 16'hFFFF, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, '0);
        vecs[1]  = mkv(1'b0, 32'h0000_1000, '0,  16'h0000, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, W_A);
        vecs[2]  = mkv(1'b1, 32'h0000_1010, W_F, 16'hFFFF, 5, 0, 1, 2'b00, 2'b00, 0, 0, 0, '0);
        vecs[3]  = mkv(1'b1, 32'h0000_1020, {DW/4{4'hA}}, 16'h00FF, 0, 3, 0, 2'b10, 2'b00, 0, 0, 1, '0);
        vecs[4]  = mkv(1'b0, 32'h0000_1020, '0,  16'h0000, 2, 0, 3, 2'b00, 2'b10, 0, 0, 1,
                       128'h0000000000000000AAAAAAAAAAAAAAAA);
        vecs[5]  = mkv(1'b0, 32'h0000_1000, '0,  16'h0000, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, W_A);
        vecs[6]  = mkv(1'b0, 32'h0000_1010, '0,  16'h0000, 0, 0, 0, 2'b00, 2'b00, 2, 1, 0, W_F);
        vecs[7]  = mkv(1'b1, 32'h0000_1030, W_X, 16'hF00F, 2, 2, 0, 2'b00, 2'b00, 0, 1, 0, '0);
        vecs[8]  = mkv(1'b0, 32'h0000_1030, '0,  16'h0000, 1, 0, 1, 2'b00, 2'b00, 10, 0, 0,
                       128'h001122330000000000000000CCDDEEFF);
        vecs[9]  = mkv(1'b1, 32'h0000_1040, W_D, 16'hFFFF, 1, 1, 2, 2'b11, 2'b00, 3, 0, 1, '0);
        vecs[10] = mkv(1'b0, 32'h0000_1040, '0,  16'h0000, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, W_D);

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        slave_idle();

        repeat (2) @(negedge clk);
        check("reset_ctrl", DW'({cmd_ready, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid,
                                 m_axil_bready, m_axil_rready, rsp_valid, rsp_err}), '0);
        check("reset_addr", DW'({m_axil_awaddr, m_axil_araddr, m_axil_awprot, m_axil_arprot}), '0);
        check("reset_wdata", m_axil_wdata, '0);
        check("reset_wstrb", DW'(m_axil_wstrb), '0);
        check("reset_rsp_rdata", rsp_rdata, '0);
        rst = 1'b0;
        #1 check("cmd_ready_before_edge", DW'(cmd_ready), DW'(0));
        @(negedge clk);
        check("cmd_ready_after_release", DW'(cmd_ready), DW'(1));

        for (int i = 0; i <= 5; i++) run_vec(i, vecs[i]);

        // Reset while a write is stalled on AW/W
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h0000_1050;
        cmd_wdata = W_D; cmd_wstrb = '1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("midrst_awvalid_up", DW'({m_axil_awvalid, m_axil_wvalid}), DW'(2'b11));
        #2 rst = 1'b1;
        #1 check("midrst_async_clear", DW'({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid,
                                            m_axil_bready, m_axil_rready, rsp_valid, cmd_ready}), '0);
        check("midrst_addr_clear", DW'(m_axil_awaddr), '0);
        m_axil_bvalid = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("midrst_ready_low", DW'(cmd_ready), DW'(0));
        @(negedge clk);
        check("midrst_ready_high", DW'(cmd_ready), DW'(1));
        repeat (3) @(negedge clk);
        check("midrst_no_rsp", DW'({rsp_valid, m_axil_awvalid, m_axil_wvalid, m_axil_bready}), '0);
        m_axil_bvalid = 1'b0;
        $display("seq midrst addr=%h rsp_valid=%0d cmd_ready=%0d", 32'h0000_1050, rsp_valid, cmd_ready);

        for (int i = 6; i <= 10; i++) run_vec(i, vecs[i]);

        check("prot_const", DW'({m_axil_awprot, m_axil_arprot}), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 Parameter DATA_WIDTH, default 128, SHALL set the AXI-lite and command data width.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the AXI-lite and command address width.
REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8, SHALL set the write-strobe width.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-008 cmd_we  in  1  1 = write, 0 = read.
REQ-009 cmd_addr / cmd_wdata / cmd_wstrb  in  ADDR_WIDTH / DATA_WIDTH / STRB_WIDTH  command payload.
REQ-010 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-011 rsp_rdata / rsp_err  out  DATA_WIDTH / 1  read data (0 for writes), error flag.
REQ-012 m_axil_awaddr, awprot, awvalid / awready  out, out, out / in  ADDR_WIDTH, 3, 1 / 1  AXI-lite AW channel.
REQ-013 m_axil_wdata, wstrb, wvalid / wready  out, out, out / in  DATA_WIDTH, STRB_WIDTH, 1 / 1  AXI-lite W channel.
REQ-014 m_axil_bresp, bvalid / bready  in, in / out  2, 1 / 1  AXI-lite B channel.
REQ-015 m_axil_araddr, arprot, arvalid / arready  out, out, out / in  ADDR_WIDTH, 3, 1 / 1  AXI-lite AR channel.
REQ-016 m_axil_rdata, rresp, rvalid / rready  in, in, in / out  DATA_WIDTH, 2, 1 / 1  AXI-lite R channel.

Function
REQ-017 The FSM SHALL have states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
REQ-018 cmd_ready SHALL be 1 only in IDLE; accept = cmd_valid & cmd_ready; the payload is registered on accept.
REQ-019 On accept the FSM SHALL go to WR_REQ if cmd_we = 1, else to RD_REQ; AXI valids SHALL assert the cycle after accept (registered outputs, no combinational cmd-to-AXI path).
REQ-020 In WR_REQ, awvalid and wvalid SHALL assert together, and each SHALL deassert only after its own handshake; the two handshakes SHALL be accepted in either order or in the same cycle.
REQ-021 WR_REQ SHALL go to WR_RESP on the cycle after both AW and W handshakes have completed; bready SHALL be 1 only in WR_RESP.
REQ-022 WR_RESP SHALL go to RSP on bvalid, capturing rsp_err = (bresp != 0) and rsp_rdata = 0.
REQ-023 In RD_REQ, arvalid SHALL be held until arready; the FSM SHALL then go to RD_DATA, with rready = 1 only in RD_DATA.
REQ-024 RD_DATA SHALL go to RSP on rvalid, capturing rsp_rdata = rdata and rsp_err = (rresp != 0).
REQ-025 In RSP, rsp_valid SHALL be 1 with stable outputs until rsp_ready; the FSM SHALL go to IDLE on the cycle after the rsp handshake, so back-to-back commands cost at least 1 idle cycle.
REQ-026 awprot and arprot SHALL be constant 3'b000.
REQ-027 Address and data SHALL pass through unmodified, with no alignment or masking.
REQ-028 Addr/data/strb outputs SHALL be stable whenever their valid is 1.
REQ-029 No valid SHALL drop before its handshake completes.
REQ-030 Exactly one AXI transaction SHALL be outstanding at a time.
REQ-031 An early bvalid or rvalid (before bready or rready) SHALL be ignored until the matching state.

Reset
REQ-032 While rst = 1, the FSM SHALL be in IDLE; all valids, bready, rready, rsp_valid, rsp_err = 0; addr/data/strb/rsp_rdata = 0; cmd_ready = 0.
REQ-033 cmd_ready SHALL rise on the first clk edge after rst deasserts.
REQ-034 Reset mid-transaction SHALL abandon the transaction immediately, with no response generated.

Verification
REQ-035 Write 0x1000, wdata = 0x0123...CDEF, wstrb = 0xFFFF, then read 0x1000 against axil_ram -> rsp_err = 0 and rsp_rdata equals the written data.
REQ-036 awready held 0 for 5 cycles while wready = 1 -> wvalid drops after its handshake, awvalid is held 5 cycles, and exactly one bready window occurs.
REQ-037 Responder returns rresp = 2'b10 for a read -> rsp_valid with rsp_err = 1; the next command still completes with rsp_err = 0.
REQ-038 rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_rdata are stable for 10 cycles, cmd_ready stays 0, and no new AXI valid asserts.
REQ-039 rst pulsed while awvalid = 1 -> all valids are 0 in the same cycle, no rsp_valid is produced, and cmd_ready = 1 on the first clk after release.
